audio_i2s_out: RTL and testbench
================================

# audio_i2s_out

Downstream stage of the PSG: paces sample generation and serializes the mixed stereo result to an external I2S DAC. It issues the one-cycle `next_sample` strobe that starts a PSG channel pass and latches the PSG's 23-bit signed left/right sums once per frame. It scales and saturates each sum to 16 bits and shifts the pair out as a standard I2S frame (bck, lrck, sdata). It sits between the PSG outputs and the board's audio DAC pins.

## Interface
Parameters:
- `BCK_DIV`, default 8: clk cycles per half bck period (legal 2..255); frame period = 64·BCK_DIV clk.
- `SHIFT`, default 7: arithmetic right shift applied to the 23-bit input before 16-bit conversion (legal 0..7).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; sampled every clk.
- `left_audio`  in  23  signed left sum from PSG.
- `right_audio`  in  23  signed right sum from PSG.
- `next_sample`  out  1  one-clk pulse at each frame start; drives PSG `next_sample`.
- `i2s_bck`  out  1  bit clock.
- `i2s_lrck`  out  1  word select (0 = left, 1 = right).
- `i2s_sdata`  out  1  serial data, MSB first.

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN.
- IDLE: divider, slot counter, and all outputs held 0. When `enable` = 1, perform a frame-start action and go to RUN.
- Frame-start action (single clk):
  - pulse `next_sample`;
  - load frame word W = {conv(left_audio), conv(right_audio)}, where W[31] is the left MSB;
  - slot ← 0, divider ← 0, bck ← 0.
- RUN, divider: counts 0..BCK_DIV-1. At terminal count it wraps and bck toggles.
  - bck rising: no other output changes.
  - bck falling: slot advances; lrck and sdata update on that same clk.
- Slot mapping (I2S one-bit delay):
  - lrck = (slot ≥ 16).
  - Slot k in 1..31 carries W[32-k].
  - Slot 0 carries the previous frame's W[0] (right LSB); 0 after IDLE.
- Frame boundary = bck falling edge where slot would go 31 → 0.
  - enable = 1: perform frame-start action and stay in RUN.
  - enable = 0: go to IDLE with outputs 0. A mid-frame deassert always completes the current frame.
- conv(x):
  - y = x >>> SHIFT (sign-extending).
  - If y > 32767, result = 16'h7FFF; if y < -32768, result = 16'h8000; else y[15:0].
  - Saturation applies only when AUDIO_SATURATE_EN is defined.
- Inputs are sampled only at frame-start clocks. The PSG updates its outputs about 100 clk after `next_sample`, so each frame carries the result of the previous `next_sample` (one frame of latency).

## Timing
- Reset values: next_sample = 0, i2s_bck = 0, i2s_lrck = 0, i2s_sdata = 0; state IDLE, counters 0, W = 0.
- `rst` mid-frame: all outputs are 0 on the clk after rst is sampled high. No partial frame resumes.
- `enable` rising in IDLE: next_sample is high in the following clk. The first bck rising edge occurs BCK_DIV clk after that.
- next_sample is exactly 1 clk wide. Its period in continuous RUN is exactly 64·BCK_DIV clk (512 at the default).
- All outputs are registered; there is no combinational path from inputs to outputs.
- sdata and lrck change only on the clk of a bck falling edge. They are stable for BCK_DIV clk on either side of each rising edge.

## Configuration
- Macro: `AUDIO_SATURATE_EN`.
- Defined: conv clamps to 16'h7FFF / 16'h8000 as above.
- Undefined: conv outputs y[15:0] (two's-complement wrap) and the clamp comparators are removed.

## Structure
- Shared package `audio_pkg`:
  - constants SAMPLE_W = 16, PSG_W = 23, SLOTS = 32;
  - state typedef {IDLE, RUN}.
- Sub-module `audio_sample_conv`: combinational shift + optional saturate, PSG_W in → SAMPLE_W out. Instantiated twice (left, right).
- Top level holds the FSM, divider, slot counter, W and shift register, and the delayed-bit register.

## Test plan
- Reset then enable = 1, BCK_DIV = 8: next_sample pulses every 512 clk; bck period = 16 clk; lrck period = 32 bck.
- SHIFT = 7, left = 23'h3FFF80, right = 23'h7FFF80: decoded frame is L = 16'h7FFF, R = 16'hFFFF. Bit 15 appears in slots 1 and 17; the right LSB appears in slot 0 of the next frame.
- SHIFT = 4, left = 23'h100000, right = 23'h700000: with the macro, L = 16'h7FFF and R = 16'h8000; without it, L = 16'h0000 and R = 16'h0000.
- Drop enable at slot 10: the frame completes to slot 31, then all outputs are 0, next_sample stays 0, and lrck shows no further edges.
- Assert rst at slot 20 for 1 clk: outputs are 0 on the next clk. Re-enable: a fresh next_sample appears and the first frame's slot 0 carries sdata = 0.
- Change inputs mid-frame: the serialized data is unchanged until the next frame-start clk.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, slot count and FSM state type for the I2S output stage.
package audio_pkg;
    localparam int SAMPLE_W = 16;
    localparam int PSG_W = 23;
    localparam int SLOTS = 32;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/audio_sample_conv.sv
// audio_sample_conv: arithmetic-shift a PSG sum down to a 16-bit sample.
// Clamps to the 16-bit range when AUDIO_SATURATE_EN is defined, otherwise wraps.
module audio_sample_conv
    import audio_pkg::*;
#(
    parameter int SHIFT = 7
) (
    input  logic signed [PSG_W-1:0]    x,
    output logic        [SAMPLE_W-1:0] y
);
`ifdef AUDIO_SATURATE_EN
    localparam logic signed [PSG_W-1:0] SAT_MAX = PSG_W'(32767);
    localparam logic signed [PSG_W-1:0] SAT_MIN = PSG_W'(-32768);
    logic signed [PSG_W-1:0] s;
    always_comb begin
        s = x >>> SHIFT;
        y = s > SAT_MAX ? 16'h7FFF : s < SAT_MIN ? 16'h8000 : s[SAMPLE_W-1:0];
    end
`else
    assign y = SAMPLE_W'(x >>> SHIFT);
`endif
endmodule

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: paces PSG sample passes and shifts the stereo result out as I2S.
// Optional clamping of out-of-range samples is enabled by AUDIO_SATURATE_EN.
module audio_i2s_out
    import audio_pkg::*;
#(
    parameter int BCK_DIV = 8,
    parameter int SHIFT   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PSG_W-1:0] left_audio,
    input  logic [PSG_W-1:0] right_audio,
    output logic             next_sample,
    output logic             i2s_bck,
    output logic             i2s_lrck,
    output logic             i2s_sdata
);
    state_t                    state, state_nxt;
    logic [7:0]                div;
    logic [4:0]                slot;
    logic [2*SAMPLE_W-1:0]     w;
    logic [SAMPLE_W-1:0]       l_conv, r_conv;
    logic                      tick, fall, wrap, start;

    audio_sample_conv #(.SHIFT(SHIFT)) u_conv_l (.x(left_audio),  .y(l_conv));
    audio_sample_conv #(.SHIFT(SHIFT)) u_conv_r (.x(right_audio), .y(r_conv));

    always_comb begin
        tick      = div == 8'(BCK_DIV - 1);
        fall      = state == RUN && tick && i2s_bck;
        wrap      = fall && slot == 5'(SLOTS - 1);
        start     = enable && (state == IDLE || wrap);
        state_nxt = start ? RUN : wrap ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Slot k carries W[32-k]; slot 0 repeats the previous frame's right LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_sample <= 1'b0;
            w           <= '0;
            slot        <= '0;
            div         <= '0;
            i2s_bck     <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_sdata   <= 1'b0;
        end else begin
            next_sample <= start;
            if (start) begin
                w         <= {l_conv, r_conv};
                slot      <= '0;
                div       <= '0;
                i2s_bck   <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_sdata <= state == RUN && w[0];
            end else if (state == IDLE || wrap) begin
                slot      <= '0;
                div       <= '0;
                i2s_bck   <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_sdata <= 1'b0;
            end else begin
                div <= tick ? 8'd0 : div + 8'd1;
                if (tick) i2s_bck <= ~i2s_bck;
                if (fall) begin
                    slot      <= slot + 5'd1;
                    i2s_lrck  <= slot >= 5'd15;
                    i2s_sdata <= w[5'(SLOTS - 1) - slot];
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_out.sv
// tb_audio_i2s_out: table-driven frame decode of two instances (SHIFT=7 and SHIFT=4)
// plus directed reset, enable-drop and restart sequences.
module tb_audio_i2s_out;
    localparam int BD = 8;

    logic        clk = 0, rst = 1, enable = 0;
    logic [22:0] left_audio = '0, right_audio = '0;
    logic        ns7, bck7, lr7, sd7, ns4, bck4, lr4, sd4;
    logic        prev_bck = 0, rise = 0;
    int          passed = 0, total = 0;

    typedef struct {
        logic [22:0] l, r;
        logic [31:0] e7, e4;
    } vec_t;
    vec_t v[6];

    audio_i2s_out #(.BCK_DIV(BD), .SHIFT(7)) dut (
        .clk(clk), .rst(rst), .enable(enable), .left_audio(left_audio), .right_audio(right_audio),
        .next_sample(ns7), .i2s_bck(bck7), .i2s_lrck(lr7), .i2s_sdata(sd7));
    audio_i2s_out #(.BCK_DIV(BD), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .left_audio(left_audio), .right_audio(right_audio),
        .next_sample(ns4), .i2s_bck(bck4), .i2s_lrck(lr4), .i2s_sdata(sd4));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        rise = bck7 && !prev_bck;
        prev_bck = bck7;
    endtask

    task automatic wait_rise(output bit ok);
        ok = 0;
        for (int t = 0; t < 4 * BD && !ok; t++) begin
            tick();
            ok = rise;
        end
    endtask

    task automatic wait_ns(output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 2000) begin
            tick();
            n++;
            found = ns7;
        end
        if (!found) n = -1;
    endtask

    // Decodes one frame starting right after next_sample was seen; b[31] is slot 0.
    task automatic capture(input int change_at, input logic [22:0] nl, input logic [22:0] nr,
                           output logic [31:0] b7, output logic [31:0] b4, output int lr_err,
                           output int first_rise, output int nticks, output int ns_seen);
        bit got;
        b7 = '0; b4 = '0; lr_err = 0; first_rise = -1; nticks = 0; ns_seen = 0;
        for (int k = 0; k < 32; k++) begin
            got = 0;
            for (int t = 0; t < 4 * BD && !got; t++) begin
                tick();
                nticks++;
                ns_seen += int'(ns7);
                got = rise;
            end
            if (!got) lr_err++;
            if (k == 0) first_rise = nticks;
            b7 = {b7[30:0], sd7};
            b4 = {b4[30:0], sd4};
            if (lr7 !== (k >= 16) || lr4 !== lr7 || bck4 !== bck7) lr_err++;
            if (k == 3) begin left_audio = ~nl; right_audio = ~nr; end
            if (k == change_at) begin left_audio = nl; right_audio = nr; end
        end
    endtask

    initial begin
        logic [31:0] b7, b4, exp0;
        int lr_err, fr, nt, nss, n, got, nz;
        bit ok;
        v[0] = '{23'h3FFF80, 23'h7FFF80, 32'h7FFF_FFFF, 32'h0};
        v[1] = '{23'h100000, 23'h700000, 32'h2000_E000, 32'h0};
        v[2] = '{23'h000000, 23'h000000, 32'h0000_0000, 32'h0000_0000};
        v[3] = '{23'h012345, 23'h7EDCBA, 32'h0246_FDB9, 32'h1234_EDCB};
        v[4] = '{23'h07FFFF, 23'h780000, 32'h0FFF_F000, 32'h7FFF_8000};
        v[5] = '{23'h080000, 23'h77FFF0, 32'h1000_EFFF, 32'h0};
`ifdef AUDIO_SATURATE_EN
        v[0].e4 = 32'h7FFF_FFF8; v[1].e4 = 32'h7FFF_8000; v[5].e4 = 32'h7FFF_8000;
`else
        v[0].e4 = 32'hFFF8_FFF8; v[1].e4 = 32'h0000_0000; v[5].e4 = 32'h8000_7FFF;
`endif
        repeat (3) tick();
        check("reset_next_sample", {31'b0, ns7}, 0);
        check("reset_bck", {31'b0, bck7}, 0);
        check("reset_lrck", {31'b0, lr7}, 0);
        check("reset_sdata", {31'b0, sd7}, 0);
        rst = 0;
        repeat (4) tick();
        check("idle_outputs", {24'b0, ns7, bck7, lr7, sd7, ns4, bck4, lr4, sd4}, 0);

        left_audio = v[0].l; right_audio = v[0].r; enable = 1;
        wait_ns(n);
        check("enable_latency", n, 1);
        for (int i = 0; i < 6; i++) begin
            capture(20, v[(i + 1) % 6].l, v[(i + 1) % 6].r, b7, b4, lr_err, fr, nt, nss);
            check($sformatf("data7_v%0d", i), {1'b0, b7[30:0]}, {1'b0, v[i].e7[31:1]});
            check($sformatf("data4_v%0d", i), {1'b0, b4[30:0]}, {1'b0, v[i].e4[31:1]});
            exp0 = (i == 0) ? 32'd0 : {30'b0, v[i - 1].e7[0], v[i - 1].e4[0]};
            check($sformatf("slot0_v%0d", i), {30'b0, b7[31], b4[31]}, exp0);
            check($sformatf("lrck_v%0d", i), lr_err, 0);
            check($sformatf("ns_width_v%0d", i), nss, 0);
            if (i == 0) check("first_bck_rise", fr, BD);
            wait_ns(n);
            check($sformatf("period_v%0d", i), nt + n, 64 * BD);
        end

        // Reset at slot 20 of a frame whose slot 0 carries a 1.
        got = 0;
        for (int k = 0; k < 21; k++) begin
            wait_rise(ok);
            got += int'(ok);
            if (k == 0) check("pre_rst_slot0", {31'b0, sd7}, {31'b0, v[5].e7[0]});
        end
        check("pre_rst_rises", got, 21);
        rst = 1;
        tick();
        check("rst_clears", {28'b0, ns7, bck7, lr7, sd7}, 0);
        rst = 0;
        wait_ns(n);
        check("restart_latency", n, 1);
        capture(20, v[0].l, v[0].r, b7, b4, lr_err, fr, nt, nss);
        check("rst_slot0", {31'b0, b7[31]}, 0);
        check("rst_data7", {1'b0, b7[30:0]}, {1'b0, v[0].e7[31:1]});
        wait_ns(n);
        check("rst_period", nt + n, 64 * BD);

        // Drop enable at slot 10: frame must finish, then everything stays 0.
        got = 0;
        for (int k = 0; k < 32; k++) begin
            wait_rise(ok);
            got += int'(ok);
            if (k == 10) enable = 0;
            if (k == 31) check("drop_last_lrck", {31'b0, lr7}, 1);
        end
        check("drop_completes", got, 32);
        repeat (2 * BD) tick();
        nz = 0;
        repeat (600) begin
            tick();
            nz += int'(ns7 | bck7 | lr7 | sd7);
        end
        check("drop_idle", nz, 0);

        enable = 1;
        wait_ns(n);
        check("reenable_latency", n, 1);
        capture(40, v[0].l, v[0].r, b7, b4, lr_err, fr, nt, nss);
        check("idle_slot0", {31'b0, b7[31]}, 0);
        check("reenable_data7", {1'b0, b7[30:0]}, {1'b0, v[0].e7[31:1]});
        check("reenable_lrck", lr_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
